// File: rtl/hilo_mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up at the end.
module hilo_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic             rd_req_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // state | meaning
    // IDLE  | waiting for start / servicing MTHI, MTLO
    // CALC  | one setup cycle, then one multiply/divide iteration per cycle
    // FIX   | sign correction, HI/LO write, done pulse
    // DIVZ  | divide by zero: HI=a, LO=all ones
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DIVZ} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             setup_q, setup_d;
    logic             is_div_q, is_div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign op_signed = ~op_i[0];
    assign op_div    = op_i[1];
    assign a_neg     = op_signed & a_i[WIDTH-1];
    assign b_neg     = op_signed & b_i[WIDTH-1];
    assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

    // Multiply: acc_lo holds the multiplier and receives product bits shifted in from acc_hi.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_fix  = neg_quo_q ? (~prod + 1'b1) : prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        setup_d   = setup_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (op_div && (b_i == '0)) begin
                        state_d  = S_DIVZ;
                        acc_hi_d = a_i;
                    end else begin
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        setup_d   = 1'b1;
                        is_div_d  = op_div;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        acc_hi_d  = '0;
                        acc_lo_d  = op_div ? a_mag : b_mag;
                        opnd_d    = op_div ? b_mag : a_mag;
                    end
                end else begin
                    if (mthi_i) hi_d = a_i;
                    if (mtlo_i) lo_d = a_i;
                end
            end
            S_CALC: begin
                if (setup_q) begin
                    setup_d = 1'b0;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH+1]) acc_hi_d = div_diff[WIDTH-1:0];
                        else                    acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_quo_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                    hi_d = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DIVZ: begin
                hi_d    = acc_hi_q;
                lo_d    = '1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            setup_q   <= 1'b0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            setup_q   <= setup_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign stall_o = rd_req_i & busy_o;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_mdu_seq.sv
// Scoreboard bench for hilo_mdu_seq: directed ops push expected HI/LO, a monitor checks on done.
module tb_hilo_mdu_seq;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, mthi_i, mtlo_i, rd_req_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o, stall_o;
    logic [31:0] hi_o, lo_o;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    hilo_mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .rd_req_i(rd_req_i),
        .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi_o, lo_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", hi_o, e.h);
                check("result_lo", lo_o, e.l);
            end
        end
    end

    // Issues one op and measures latency, busy and stall cycles. Optionally injects
    // start+mthi mid-flight, or issues the start together with mtlo.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic rdreq, input logic inject,
                          input logic with_mtlo, input logic [31:0] mid_lo);
        int k, busy_n, stall_n;
        exp_t e;
        e.h = eh;
        e.l = el;
        sb.push_back(e);
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1; rd_req_i = rdreq; mtlo_i = with_mtlo;
        @(negedge clk_i);
        start_i = 1'b0; mtlo_i = 1'b0;
        if (with_mtlo) check({nm, "_mtlo_dropped"}, lo_o, mid_lo);
        k = 1; busy_n = 0; stall_n = 0;
        while (done_o !== 1'b1 && k < 100) begin
            busy_n  += int'(busy_o);
            stall_n += int'(stall_o);
            @(negedge clk_i);
            k++;
            if (inject && k == 5) begin
                start_i = 1'b1; mthi_i = 1'b1; a_i = 32'hDEADBEEF;
            end else if (inject && k == 6) begin
                start_i = 1'b0; mthi_i = 1'b0;
            end
        end
        check({nm, "_latency"}, 32'(k - 1), 32'(exp_lat));
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({nm, "_stall_cycles"}, 32'(stall_n), rdreq ? 32'(exp_lat) : 32'd0);
        check({nm, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
        check({nm, "_stall_at_done"}, {31'd0, stall_o}, 32'd0);
        rd_req_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; rd_req_i = 1'b0;
        op_i = 2'b00; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);

        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'h2, 34, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0);
        run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'h5, 34, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0, 0, 0);
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0, 0);
        run_op("divu_zero", DIVU, 32'd100, 32'h0, 1, 32'h00000064, 32'hFFFFFFFF, 0, 0, 0, 0);
        run_op("divu_stall", DIVU, 32'd1000, 32'd7, 34, 32'h00000006, 32'h0000008E, 1, 0, 0, 0);
        run_op("div_minint", DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 0, 0, 0, 0);
        run_op("div_negb", DIV, 32'd7, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 0, 0, 0, 0);
        run_op("mult_negneg", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h0, 32'h00000001, 0, 0, 0, 0);
        run_op("div_zero_s", DIV, 32'hFFFFFFF9, 32'h0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, 0, 0, 0);

        // Reset mid-operation aborts it: no done may follow.
        @(negedge clk_i);
        op_i = MULTU; a_i = 32'd5; b_i = 32'd5; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_hi", hi_o, 32'h0);
        check("abort_lo", lo_o, 32'h0);
        repeat (40) @(negedge clk_i);
        run_op("multu_after_rst", MULTU, 32'd3, 32'd4, 34, 32'h0, 32'h0000000C, 0, 0, 0, 0);

        run_op("mult_inject", MULT, 32'd6, 32'd7, 34, 32'h0, 32'h0000002A, 0, 1, 0, 0);
        @(negedge clk_i);
        mthi_i = 1'b1; a_i = 32'hDEADBEEF;
        @(negedge clk_i);
        mthi_i = 1'b0;
        check("mthi_hi", hi_o, 32'hDEADBEEF);
        check("mthi_lo_kept", lo_o, 32'h0000002A);
        mthi_i = 1'b1; mtlo_i = 1'b1; a_i = 32'h12345678;
        @(negedge clk_i);
        mthi_i = 1'b0; mtlo_i = 1'b0;
        check("mthilo_hi", hi_o, 32'h12345678);
        check("mthilo_lo", lo_o, 32'h12345678);
        run_op("divu_with_mtlo", DIVU, 32'd20, 32'd3, 34, 32'h00000002, 32'h00000006, 0, 0, 1, 32'h12345678);

        repeat (3) @(negedge clk_i);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
